// File: rtl/cdc_evt_pkg.sv
// Shared constants and the event record type for the toggle event receiver.
package cdc_evt_pkg;

  localparam int MIN_SYNC_STAGES = 2;

  // Record fields are sized for the largest legal configuration (32 channels).
  localparam int REC_CH_W  = 5;
  localparam int REC_CNT_W = 16;

  typedef struct packed {
    logic [REC_CH_W-1:0]  ch;
    logic [REC_CNT_W-1:0] count;
  } evt_rec_t;

endpackage

// File: rtl/cdc_evt_rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last granted channel.
module cdc_evt_rr_arbiter #(
  parameter  int NUM_CH = 8,
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              out_clk,
  input  logic              out_reset,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              grant_any
);

  logic [IDX_W-1:0] last_q;

  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cidx;
    cand      = 0;
    cidx      = '0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = int'(last_q) + k;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      cidx = IDX_W'(cand);
      if (!grant_any && req[cidx]) begin
        grant_any   = 1'b1;
        grant[cidx] = 1'b1;
        grant_idx   = cidx;
      end
    end
  end

  always_ff @(posedge out_clk or posedge out_reset) begin
    if (out_reset) begin
      last_q <= '0;
    end else if (advance && grant_any) begin
      last_q <= grant_idx;
    end
  end

endmodule

// File: rtl/cdc_toggle_event_receiver.sv
// Synchronizes toggle lines, counts events per channel and issues round-robin event records.
// Define CDC_TOGGLE_EVT_OVF_EN to enable the sticky per-channel overflow flags.
module cdc_toggle_event_receiver
  import cdc_evt_pkg::*;
#(
  parameter  int NUM_CH      = 8,
  parameter  int SYNC_STAGES = 2,
  parameter  int CNT_W       = 4,
  localparam int IDX_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              out_clk,
  input  logic              out_reset,
  input  logic [NUM_CH-1:0] in_toggle,
  output logic [NUM_CH-1:0] out_pulse,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [IDX_W-1:0]  evt_ch,
  output logic [CNT_W-1:0]  evt_count,
  output logic [NUM_CH-1:0] overflow,
  input  logic [NUM_CH-1:0] ovf_clear
);

  localparam int STAGES = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;
  localparam int SUP_W  = $clog2(STAGES + 2);
  localparam logic [SUP_W-1:0] SUP_DONE = SUP_W'(STAGES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [NUM_CH-1:0] sync_q [STAGES];
  logic [NUM_CH-1:0] dly_q;
  logic [SUP_W-1:0]  sup_q;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] grant;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_any;
  logic [CNT_W-1:0]  grant_cnt;
  logic              load;
  logic              valid_q;
  evt_rec_t          rec_q;

  always_ff @(posedge out_clk or posedge out_reset) begin
    if (out_reset) begin
      for (int s = 0; s < STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= in_toggle;
      for (int s = 1; s < STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // Edge detection stays masked until the chain and delay flop have absorbed the post-reset level.
  always_ff @(posedge out_clk or posedge out_reset) begin
    if (out_reset) begin
      dly_q <= '0;
      sup_q <= '0;
    end else begin
      dly_q <= sync_q[STAGES-1];
      if (sup_q != SUP_DONE) sup_q <= sup_q + 1'b1;
    end
  end

  assign out_pulse = (sup_q == SUP_DONE) ? (sync_q[STAGES-1] ^ dly_q) : '0;

  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_CH; i++) req[i] = (cnt_q[i] != '0) || out_pulse[i];
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) grant_cnt = cnt_q[i];
    end
  end

  cdc_evt_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .out_clk   (out_clk),
    .out_reset (out_reset),
    .req       (req),
    .advance   (load),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign load = (!valid_q || evt_ready) && grant_any;

  // A channel requesting only through this cycle's pulse yields a record of one event.
  always_ff @(posedge out_clk or posedge out_reset) begin
    if (out_reset) begin
      valid_q <= 1'b0;
      rec_q   <= '0;
    end else if (!valid_q || evt_ready) begin
      valid_q <= grant_any;
      if (grant_any) begin
        rec_q.ch    <= REC_CH_W'(grant_idx);
        rec_q.count <= REC_CNT_W'((grant_cnt != '0) ? grant_cnt : CNT_W'(1));
      end
    end
  end

  always_ff @(posedge out_clk or posedge out_reset) begin
    if (out_reset) begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (load && grant[i]) begin
          cnt_q[i] <= ((cnt_q[i] != '0) && out_pulse[i]) ? CNT_W'(1) : '0;
        end else if (out_pulse[i] && (cnt_q[i] != CNT_MAX)) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign evt_valid = valid_q;
  assign evt_ch    = rec_q.ch[IDX_W-1:0];
  assign evt_count = rec_q.count[CNT_W-1:0];

  logic unused_rec_bits;
  assign unused_rec_bits = ^{rec_q.ch >> IDX_W, rec_q.count >> CNT_W};

`ifdef CDC_TOGGLE_EVT_OVF_EN
  logic [NUM_CH-1:0] ovf_q;

  always_ff @(posedge out_clk or posedge out_reset) begin
    if (out_reset) begin
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (out_pulse[i] && (cnt_q[i] == CNT_MAX)) ovf_q[i] <= 1'b1;
        else if (ovf_clear[i])                     ovf_q[i] <= 1'b0;
      end
    end
  end

  assign overflow = ovf_q;
`else
  logic unused_ovf_clear;
  assign unused_ovf_clear = ^ovf_clear;
  assign overflow         = '0;
`endif

endmodule

// File: tb/tb_cdc_toggle_event_receiver.sv
// Randomized scoreboard bench for cdc_toggle_event_receiver against an event-level reference model.
module tb_cdc_toggle_event_receiver;

  localparam int NUM_CH      = 8;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;
  // Edges from a toggle driven after edge k to the edge that consumes its pulse.
  localparam int PIPE        = SYNC_STAGES + 1;
`ifdef CDC_TOGGLE_EVT_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic              out_clk   = 1'b0;
  logic              out_reset = 1'b1;
  logic              evt_ready = 1'b0;
  logic [NUM_CH-1:0] in_toggle = '0;
  logic [NUM_CH-1:0] ovf_clear = '0;
  logic [NUM_CH-1:0] out_pulse;
  logic [NUM_CH-1:0] overflow;
  logic              evt_valid;
  logic [2:0]        evt_ch;
  logic [CNT_W-1:0]  evt_count;

  int checks   = 0;
  int failures = 0;

  cdc_toggle_event_receiver #(
    .NUM_CH(NUM_CH), .SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W)
  ) dut (
    .out_clk   (out_clk),
    .out_reset (out_reset),
    .in_toggle (in_toggle),
    .out_pulse (out_pulse),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .evt_count (evt_count),
    .overflow  (overflow),
    .ovf_clear (ovf_clear)
  );

  always #5 out_clk = ~out_clk;

  // Reference model state: pending events per channel, last grant, presented record, overflow.
  int                edge_count = 0;
  logic [NUM_CH-1:0] due [int];
  int                m_cnt [NUM_CH];
  int                m_last  = 0;
  bit                m_valid = 1'b0;
  logic [NUM_CH-1:0] m_ovf   = '0;
  int                exp_ch_q[$];
  int                exp_cnt_q[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at edge %0d", name, actual, expected, edge_count);
    end
  endtask

  task automatic resetModel();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_last  = 0;
    m_valid = 1'b0;
    m_ovf   = '0;
    due.delete();
    exp_ch_q.delete();
    exp_cnt_q.delete();
  endtask

  task automatic modelStep(input logic [NUM_CH-1:0] p, input bit ready, input logic [NUM_CH-1:0] clr);
    int win;
    win = -1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (p[i] && m_cnt[i] == CNT_MAX) m_ovf[i] = 1'b1;
      else if (clr[i])                 m_ovf[i] = 1'b0;
    end
    if (!m_valid || ready) begin
      for (int k = 1; k <= NUM_CH && win < 0; k++) begin
        int c;
        c = (m_last + k) % NUM_CH;
        if (m_cnt[c] > 0 || p[c]) win = c;
      end
      m_valid = (win >= 0);
      if (win >= 0) begin
        exp_ch_q.push_back(win);
        exp_cnt_q.push_back(m_cnt[win] > 0 ? m_cnt[win] : 1);
        m_last = win;
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (i == win)  m_cnt[i] = (m_cnt[i] > 0 && p[i]) ? 1 : 0;
      else if (p[i]) m_cnt[i] = (m_cnt[i] < CNT_MAX) ? m_cnt[i] + 1 : CNT_MAX;
    end
  endtask

  initial begin
    forever begin
      logic [NUM_CH-1:0] p;
      @(posedge out_clk);
      edge_count++;
      if (out_reset) begin
        resetModel();
      end else begin
        p = due.exists(edge_count) ? due[edge_count] : '0;
        due.delete(edge_count);
        modelStep(p, evt_ready, ovf_clear);
      end
    end
  end

  // Monitor: samples between edges and pops the scoreboard on every handshake.
  initial begin
    forever begin
      logic [NUM_CH-1:0] exp_p;
      @(negedge out_clk);
      #2;
      if (!out_reset) begin
        exp_p = due.exists(edge_count + 1) ? due[edge_count + 1] : '0;
        checkOutput("out_pulse", out_pulse, exp_p);
        checkOutput("evt_valid", evt_valid, m_valid);
        checkOutput("overflow", overflow, OVF_EN ? m_ovf : '0);
        if (evt_valid && evt_ready) begin
          if (exp_ch_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_record: got ch %0d count %0d, expected no record", evt_ch, evt_count);
          end else begin
            checkOutput("evt_ch", evt_ch, exp_ch_q.pop_front());
            checkOutput("evt_count", evt_count, exp_cnt_q.pop_front());
          end
        end
      end
    end
  end

  task automatic applyStimulus(input logic [NUM_CH-1:0] mask, input bit ready,
                               input logic [NUM_CH-1:0] clr = '0);
    int key;
    @(negedge out_clk);
    in_toggle = in_toggle ^ mask;
    evt_ready = ready;
    ovf_clear = clr;
    key = edge_count + PIPE;
    if (mask != '0) begin
      if (due.exists(key)) due[key] = due[key] | mask;
      else                 due[key] = mask;
    end
  endtask

  task automatic doReset(input logic [NUM_CH-1:0] level);
    @(negedge out_clk);
    #1;
    out_reset = 1'b1;
    #1;
    checkOutput("reset_evt_valid", evt_valid, 0);
    checkOutput("reset_out_pulse", out_pulse, 0);
    checkOutput("reset_overflow", overflow, 0);
    in_toggle = level;
    ovf_clear = '0;
    repeat (3) @(negedge out_clk);
    out_reset = 1'b0;
    repeat (6) applyStimulus('0, 1'b1);
  endtask

  initial begin
    doReset('0);

    applyStimulus(8'h08, 1'b1);
    repeat (6) applyStimulus('0, 1'b1);

    for (int n = 0; n < 5; n++) begin
      applyStimulus(8'h20, 1'b0);
      repeat (3) applyStimulus('0, 1'b0);
    end
    repeat (4) applyStimulus('0, 1'b0);
    repeat (4) applyStimulus('0, 1'b1);

    for (int n = 0; n < 17; n++) begin
      applyStimulus(8'h01, 1'b0);
      applyStimulus('0, 1'b0);
    end
    repeat (4) applyStimulus('0, 1'b0);
    applyStimulus('0, 1'b0, 8'h01);
    repeat (4) applyStimulus('0, 1'b1);

    applyStimulus(8'h46, 1'b1);
    repeat (8) applyStimulus('0, 1'b1);

    applyStimulus(8'h10, 1'b1);
    applyStimulus(8'h10, 1'b1);
    repeat (6) applyStimulus('0, 1'b1);

    applyStimulus(8'h04, 1'b0);
    repeat (5) applyStimulus('0, 1'b0);
    doReset(8'hFF);
    repeat (20) applyStimulus('0, 1'b1);

    for (int n = 0; n < 3000; n++) begin
      logic [NUM_CH-1:0] mask;
      logic [NUM_CH-1:0] clr;
      bit                rdy;
      mask = ($urandom_range(0, 2) == 0) ? (NUM_CH'($urandom) & NUM_CH'($urandom)) : '0;
      rdy  = ((n % 200) < 150) ? ($urandom_range(0, 3) != 0) : 1'b0;
      clr  = ($urandom_range(0, 15) == 0) ? NUM_CH'($urandom) : '0;
      applyStimulus(mask, rdy, clr);
      if (n == 1500) doReset(NUM_CH'($urandom));
    end

    for (int n = 0; n < 200 && (exp_ch_q.size() != 0 || m_valid); n++) applyStimulus('0, 1'b1);
    repeat (2) applyStimulus('0, 1'b1);
    checkOutput("drain_empty", exp_ch_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
